heart_manager: RTL and testbench
================================

// Module: heart_manager
// PURPOSE
//   Player-health controller feeding the heart HUD renderer: owns the heart count
//   (0..3), applies damage/heal events from game logic, enforces post-hit invincibility
//   with a blink flag, and sequences death -> game-over. All outputs are registered.
//   The renderer consumes num_heart; sprite and game-FSM logic consume the status flags.
// PARAMETERS
//   MAX_HEART    3    hearts at reset/restart; saturation ceiling (1..3, fits 2 bits)
//   INV_FRAMES   60   frame_tick count of invincibility after a non-lethal hit
//   BLINK_FRAMES 8    frame_tick count per blink half-period during invincibility
//   DEATH_FRAMES 120  frame_tick count spent in DYING before GAME_OVER
//   REGEN_FRAMES 600  frame_tick count per regenerated heart (HEART_REGEN_EN only)
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   frame_tick   in   1  one-cycle pulse per video frame (vsync edge); sole time base
//   hit          in   1  one-cycle damage pulse from collision logic
//   heal         in   1  one-cycle pickup pulse
//   restart      in   1  one-cycle pulse; synchronous return to the reset state
//   num_heart    out  2  current hearts, to HUD renderer
//   invincible   out  1  high in INVULN
//   blink        out  1  player-sprite hide flag; toggles in INVULN, else 0
//   dying        out  1  high in DYING
//   game_over    out  1  high in GAME_OVER (sticky until restart/reset)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ALIVE, num_heart=MAX_HEART, all flags 0, counters 0.
//   States: ALIVE, INVULN, DYING, GAME_OVER. Outputs update the cycle after the event.
//   Priority per cycle: restart > hit > heal > frame_tick countdown.
//   ALIVE: hit & num_heart>1 -> num_heart-1, inv_cnt=INV_FRAMES, blink=1, -> INVULN.
//          hit & num_heart==1 -> num_heart=0, die_cnt=DEATH_FRAMES, -> DYING.
//          heal -> num_heart+1, saturating at MAX_HEART (heal at max is a no-op).
//   INVULN: hit ignored. heal accepted as in ALIVE. On frame_tick: inv_cnt-1;
//          blink toggles whenever inv_cnt crosses a multiple of BLINK_FRAMES;
//          frame_tick with inv_cnt==1 -> inv_cnt=0, blink=0, -> ALIVE.
//   DYING: hit/heal ignored. frame_tick decrements die_cnt; frame_tick with die_cnt==1
//          -> GAME_OVER.
//   GAME_OVER: num_heart=0, everything but restart ignored.
//   restart in any state: same values as reset, applied on the next clock edge.
//   Simultaneous hit+heal: hit is processed, heal is dropped (not queued).
//   hit coincident with frame_tick in ALIVE: hit is processed; the new state's countdown
//   starts on the next frame_tick. Counter widths come from $clog2 of the largest
//   *_FRAMES value and never wrap (load and decrement to 0 only).
//   num_heart never leaves 0..MAX_HEART; invincible/dying/game_over are mutually
//   exclusive (one-hot with ALIVE).
// CONFIGURATION
//   HEART_REGEN_EN defined: in ALIVE with 0<num_heart<MAX_HEART, regen_cnt counts
//     frame_ticks; reaching REGEN_FRAMES adds one heart and clears regen_cnt. regen_cnt
//     clears on hit, on reaching max, and on leaving ALIVE; it holds (no count) in INVULN.
//     A regen step in the same cycle as heal counts once (still saturating).
//   HEART_REGEN_EN undefined: no regen counter is built; hearts change only on hit/heal.
// TESTING
//   Reset then 3 hits, each after invincibility expires -> num_heart 3,2,1,0; DYING
//     after the 3rd; GAME_OVER exactly 120 frame_ticks later.
//   hit, then hit at frame 10 of INVULN -> num_heart stays 2; ALIVE after 60 ticks;
//     blink toggles every 8 ticks, then 0.
//   heal at num_heart=3 -> stays 3; hit+heal in the same cycle at 3 -> 2, INVULN.
//   restart during DYING and in GAME_OVER -> next cycle num_heart=3, ALIVE, flags 0.
//   rst_n asserted mid-INVULN with clk stopped -> outputs reset immediately (async).
//   HEART_REGEN_EN, num_heart=1 -> 2 after 600 ticks, 3 after 1200, then no change.

Source files
------------

// File: rtl/heart_manager.sv
// Player-health controller: heart count, post-hit invincibility with blink, death sequencing.
// Optional HEART_REGEN_EN builds a frame-based heart regeneration counter.
module heart_manager #(
  parameter int unsigned MAX_HEART    = 3,
  parameter int unsigned INV_FRAMES   = 60,
  parameter int unsigned BLINK_FRAMES = 8,
  parameter int unsigned DEATH_FRAMES = 120,
  parameter int unsigned REGEN_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       heal,
  input  logic       restart,
  output logic [1:0] num_heart,
  output logic       invincible,
  output logic       blink,
  output logic       dying,
  output logic       game_over
);

  localparam int unsigned CNT_TOP = (INV_FRAMES > DEATH_FRAMES) ? INV_FRAMES : DEATH_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);
  localparam int unsigned PW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] INV_LD = CW'(INV_FRAMES);
  localparam logic [CW-1:0] DIE_LD = CW'(DEATH_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PH_LD  = PW'(INV_FRAMES % BLINK_FRAMES);
  localparam logic [PW-1:0] PH_TOP = PW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    MAXH   = 2'(MAX_HEART);

  if (MAX_HEART < 1 || MAX_HEART > 3 || INV_FRAMES < 1 || BLINK_FRAMES < 1 ||
      DEATH_FRAMES < 1 || REGEN_FRAMES < 1) begin : g_param_check
    $error("heart_manager: parameter out of range");
  end

  typedef enum logic [1:0] {ALIVE, INVULN, DYING, GAME_OVER} state_e;

  state_e        state_q, state_d;
  logic [1:0]    heart_q, heart_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          blink_q, blink_d;
  logic          inv_q, dying_q, go_q;

  logic [1:0]    heart_inc;
  logic [CW-1:0] cnt_dec;
  logic [PW-1:0] ph_dec;
  logic          add_heart;

`ifdef HEART_REGEN_EN
  localparam int unsigned RW = (REGEN_FRAMES > 1) ? $clog2(REGEN_FRAMES) : 1;
  localparam logic [RW-1:0] REGEN_LAST = RW'(REGEN_FRAMES - 1);

  logic [RW-1:0] regen_q, regen_d;
  logic          regen_step;

  // Counts only while ALIVE and below max; a wrap to REGEN_LAST is one heart.
  always_comb begin
    regen_d    = regen_q;
    regen_step = 1'b0;
    if (state_q == ALIVE && frame_tick && heart_q != 2'd0 && heart_q < MAXH) begin
      if (regen_q == REGEN_LAST) begin
        regen_step = 1'b1;
        regen_d    = '0;
      end else begin
        regen_d = regen_q + RW'(1);
      end
    end
    if (restart || hit || state_d != ALIVE || heart_d == MAXH) regen_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regen_q <= '0;
    else        regen_q <= regen_d;
  end
`else
  logic regen_step;
  assign regen_step = 1'b0;
`endif

  assign heart_inc = (heart_q < MAXH) ? heart_q + 2'd1 : heart_q;
  assign cnt_dec   = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
  // ph tracks cnt modulo BLINK_FRAMES without a divider.
  assign ph_dec    = (ph_q == '0) ? PH_TOP : ph_q - PW'(1);
  assign add_heart = heal | regen_step;

  always_comb begin
    state_d = state_q;
    heart_d = heart_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    blink_d = blink_q;

    if (restart) begin
      state_d = ALIVE;
      heart_d = MAXH;
      cnt_d   = '0;
      ph_d    = '0;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            if (heart_q > 2'd1) begin
              heart_d = heart_q - 2'd1;
              cnt_d   = INV_LD;
              ph_d    = PH_LD;
              blink_d = 1'b1;
              state_d = INVULN;
            end else begin
              heart_d = 2'd0;
              cnt_d   = DIE_LD;
              state_d = DYING;
            end
          end else if (add_heart) begin
            heart_d = heart_inc;
          end
        end
        INVULN: begin
          if (heal) heart_d = heart_inc;
          if (frame_tick) begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d   = '0;
              ph_d    = '0;
              blink_d = 1'b0;
              state_d = ALIVE;
            end else begin
              cnt_d = cnt_dec;
              ph_d  = ph_dec;
              if (ph_dec == '0) blink_d = ~blink_q;
            end
          end
        end
        DYING: begin
          if (frame_tick) begin
            cnt_d = cnt_dec;
            if (cnt_q <= CNT_ONE) state_d = GAME_OVER;
          end
        end
        GAME_OVER: begin
          heart_d = 2'd0;
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      heart_q <= MAXH;
      cnt_q   <= '0;
      ph_q    <= '0;
      blink_q <= 1'b0;
      inv_q   <= 1'b0;
      dying_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      heart_q <= heart_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      blink_q <= blink_d;
      inv_q   <= (state_d == INVULN);
      dying_q <= (state_d == DYING);
      go_q    <= (state_d == GAME_OVER);
    end
  end

  assign num_heart  = heart_q;
  assign invincible = inv_q;
  assign blink      = blink_q;
  assign dying      = dying_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_heart_manager.sv
// Bench for heart_manager: directed scenarios plus random traffic against a frame-level health model.
module tb_heart_manager;

  localparam int MAXH = 3;
  localparam int INV  = 60;
  localparam int BLK  = 8;
  localparam int DIE  = 120;

  localparam int ST_ALIVE = 0;
  localparam int ST_INV   = 1;
  localparam int ST_DYING = 2;
  localparam int ST_GO    = 3;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] num_heart;
  logic       invincible, blink, dying, game_over;

  int checks = 0;
  int errors = 0;

  int m_hearts, m_st, m_elapsed, m_die_left;

  always #5 if (clk_en) clk = ~clk;

  heart_manager #(
    .MAX_HEART   (MAXH),
    .INV_FRAMES  (INV),
    .BLINK_FRAMES(BLK),
    .DEATH_FRAMES(DIE),
    .REGEN_FRAMES(600)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .hit       (hit),
    .heal      (heal),
    .restart   (restart),
    .num_heart (num_heart),
    .invincible(invincible),
    .blink     (blink),
    .dying     (dying),
    .game_over (game_over)
  );

  task automatic model_reset();
    m_hearts   = MAXH;
    m_st       = ST_ALIVE;
    m_elapsed  = 0;
    m_die_left = 0;
  endtask

  // Sprite starts visible-hidden (1) and flips at every nonzero multiple of BLK passed.
  function automatic logic exp_blink();
    int r, n;
    if (m_st != ST_INV) return 1'b0;
    r = INV - m_elapsed;
    n = 0;
    for (int m = r; m < INV; m++) if (m % BLK == 0 && m > 0) n++;
    return (n % 2 == 0);
  endfunction

  task automatic model_step(input logic h, input logic he, input logic t, input logic rs);
    if (rs) begin
      model_reset();
      return;
    end
    case (m_st)
      ST_ALIVE: begin
        if (h) begin
          if (m_hearts > 1) begin
            m_hearts--;
            m_st      = ST_INV;
            m_elapsed = 0;
          end else begin
            m_hearts   = 0;
            m_st       = ST_DYING;
            m_die_left = DIE;
          end
        end else if (he && m_hearts < MAXH) m_hearts++;
      end
      ST_INV: begin
        if (he && m_hearts < MAXH) m_hearts++;
        if (t) begin
          m_elapsed++;
          if (m_elapsed == INV) m_st = ST_ALIVE;
        end
      end
      ST_DYING: begin
        if (t) begin
          m_die_left--;
          if (m_die_left == 0) m_st = ST_GO;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("num_heart",  32'(num_heart),  32'(m_hearts));
    chk("invincible", 32'(invincible), 32'(m_st == ST_INV));
    chk("blink",      32'(blink),      32'(exp_blink()));
    chk("dying",      32'(dying),      32'(m_st == ST_DYING));
    chk("game_over",  32'(game_over),  32'(m_st == ST_GO));
  endtask

  task automatic step(input logic h, input logic he, input logic t, input logic rs);
    @(negedge clk);
    hit = h; heal = he; frame_tick = t; restart = rs;
    @(posedge clk);
    model_step(h, he, t, rs);
    #1;
    hit = 1'b0; heal = 1'b0; frame_tick = 1'b0; restart = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic h, he, t, rs;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_hearts", 32'(num_heart), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Three spaced hits down to death, then exact death timing.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      chk("hit_hearts", 32'(num_heart), 32'(2 - k));
      if (k < 2) begin
        repeat (INV) step(0, 0, 1, 0);
        chk("inv_expired", 32'(invincible), 32'd0);
      end
    end
    chk("dying_entry", 32'(dying), 32'd1);
    repeat (DIE - 1) step(0, 0, 1, 0);
    chk("dying_119", 32'(dying), 32'd1);
    step(0, 0, 1, 0);
    chk("game_over_120", 32'(game_over), 32'd1);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    chk("go_sticky", 32'(game_over), 32'd1);
    step(0, 0, 0, 1);
    chk("restart_go", 32'(num_heart), 32'd3);

    // Second hit inside invincibility is ignored.
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("inv_hit_ignored", 32'(num_heart), 32'd2);
    repeat (INV - 11) step(0, 0, 1, 0);
    chk("inv_last", 32'(invincible), 32'd1);
    step(0, 0, 1, 0);
    chk("inv_done", 32'(invincible), 32'd0);
    chk("blink_done", 32'(blink), 32'd0);

    // Heal saturation and hit+heal collision.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("heal_sat", 32'(num_heart), 32'd3);
    step(1, 1, 0, 0);
    chk("hit_heal", 32'(num_heart), 32'd2);
    chk("hit_heal_inv", 32'(invincible), 32'd1);
    repeat (INV) step(0, 0, 1, 0);

    // Hit coincident with frame_tick: countdown starts on the following tick.
    step(1, 0, 1, 0);
    repeat (INV - 1) step(0, 0, 1, 0);
    chk("hit_tick_inv", 32'(invincible), 32'd1);
    step(0, 0, 1, 0);

    // Restart during DYING.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("restart_dying", 32'(num_heart), 32'd3);

    // Asynchronous reset while the clock is stopped mid-invincibility.
    step(1, 0, 0, 0);
    repeat (7) step(0, 0, 1, 0);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #10;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;

    // Random traffic; heal+tick in INVULN is kept apart.
    for (int i = 0; i < 3000; i++) begin
      h  = ($urandom_range(0, 19) == 0);
      he = ($urandom_range(0, 14) == 0);
      t  = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 399) == 0);
      if (m_st == ST_GO && $urandom_range(0, 29) == 0) rs = 1'b1;
      if (m_st == ST_INV && t) he = 1'b0;
      step(h, he, t, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
